// File: rtl/fft_frame_streamer.sv
// Frame player and capture engine around the FFT core: replays one stored input
// frame with valid/start sequencing and records the FFT output after a programmable delay.
module fft_frame_streamer #(
  parameter int unsigned DW        = 16,
  parameter int unsigned FRAME_LEN = 384,
  parameter int unsigned CAP_LEN   = 384,
  parameter int unsigned AW        = 9,
  parameter int unsigned CW        = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          run,
  input  logic          loop,
  input  logic [CW-1:0] skip,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_re,
  input  logic [DW-1:0] ld_im,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_re,
  output logic [DW-1:0] rd_im,
  output logic          fft_valid,
  output logic          fft_start,
  output logic [DW-1:0] fft_inReal,
  output logic [DW-1:0] fft_inImag,
  input  logic [DW-1:0] fft_outReal,
  input  logic [DW-1:0] fft_outImag,
  output logic          busy,
  output logic          done,
  output logic [7:0]    frame_cnt
);

  localparam int unsigned XW = CW + 1;
  localparam int unsigned BW = AW + 1;
  localparam logic [XW-1:0] FL_X = XW'(FRAME_LEN);
  localparam logic [XW-1:0] CL_X = XW'(CAP_LEN);
  localparam logic [BW-1:0] FL_B = BW'(FRAME_LEN);
  localparam logic [BW-1:0] CL_B = BW'(CAP_LEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  logic [DW-1:0] stim_re [FRAME_LEN];
  logic [DW-1:0] stim_im [FRAME_LEN];
  logic [DW-1:0] cap_re  [CAP_LEN];
  logic [DW-1:0] cap_im  [CAP_LEN];

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] skip_l, skip_n;
  logic [XW-1:0] last, last_n;
  logic [XW-1:0] span, last_calc;
  logic [CW-1:0] cap_off;
  logic          fin;
  logic          in_frame;
  logic          cap_hit;
  logic          ld_ok;
  logic          cap_we;
  logic [AW-1:0] cap_idx;

  // Internal count leads the registered FFT-facing outputs by one cycle (prefetch slot).
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    skip_n    = skip_l;
    last_n    = last;
    fin       = 1'b0;
    span      = {1'b0, skip} + CL_X;
    last_calc = ((span > FL_X) ? span : FL_X) - XW'(1);
    case (state)
      IDLE, DONE: begin
        if (run) begin
          state_n = RUN;
          cnt_n   = '0;
          skip_n  = skip;
          last_n  = last_calc;
        end
      end
      RUN: begin
        if ({1'b0, cnt} == last) begin
          fin = 1'b1;
          if (loop) begin
            cnt_n  = '0;
            skip_n = skip;
            last_n = last_calc;
          end else begin
            state_n = DONE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      skip_l <= '0;
      last   <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      skip_l <= skip_n;
      last   <= last_n;
    end
  end

  always_comb begin
    cap_off  = cnt - skip_l;
    in_frame = (state == RUN) && ({1'b0, cnt} < FL_X);
    cap_hit  = (state == RUN) && (cnt >= skip_l) && ({1'b0, cap_off} < CL_X);
    ld_ok    = ld_we && (state != RUN) && ({1'b0, ld_addr} < FL_B);
  end

  // Registered FFT drive, status and capture-write pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fft_valid  <= 1'b0;
      fft_start  <= 1'b0;
      fft_inReal <= '0;
      fft_inImag <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      frame_cnt  <= '0;
      cap_we     <= 1'b0;
      cap_idx    <= '0;
      rd_re      <= '0;
      rd_im      <= '0;
    end else begin
      fft_valid  <= in_frame;
      fft_start  <= (state == RUN) && (cnt == '0);
      fft_inReal <= in_frame ? stim_re[AW'(cnt)] : '0;
      fft_inImag <= in_frame ? stim_im[AW'(cnt)] : '0;
      busy       <= (state == RUN);
      done       <= fin;
      frame_cnt  <= frame_cnt + 8'(fin);
      cap_we     <= cap_hit;
      cap_idx    <= AW'(cap_off);
      rd_re      <= ({1'b0, rd_addr} < CL_B) ? cap_re[rd_addr] : '0;
      rd_im      <= ({1'b0, rd_addr} < CL_B) ? cap_im[rd_addr] : '0;
    end
  end

  // Buffer storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (ld_ok) begin
      stim_re[ld_addr] <= ld_re;
      stim_im[ld_addr] <= ld_im;
    end
    if (cap_we) begin
      cap_re[cap_idx] <= fft_outReal;
      cap_im[cap_idx] <= fft_outImag;
    end
  end

endmodule

// File: doc/fft_frame_streamer.md
# fft_frame_streamer

Synthesizable frame player and capture engine for the FFT datapath. It holds one input frame of complex samples and streams it into `Top_FFT` with `valid` and `start` sequencing. After a programmable latency it records the FFT output stream into a capture buffer that a host reads back. This replaces the fixed 384-sample, fixed-latency, simulation-only stimulus and dump flow, so frames can be replayed on silicon and FPGA.

## Interface
- `DW`, 16: sample width per real/imag component (two's complement, passed through unmodified)
- `FRAME_LEN`, 384: samples per input frame
- `CAP_LEN`, 384: output samples captured per run
- `AW`, 9: address width for the stimulus and capture buffers; must be ≥ clog2(max(FRAME_LEN, CAP_LEN))
- `CW`, 10: width of the cycle counter and of `skip`; must hold `skip + CAP_LEN`
- `clk` in 1: single clock, all logic on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `run` in 1: 1-cycle pulse; starts a run, honoured only in IDLE or DONE
- `loop` in 1: if high when a run ends, the next run starts immediately
- `skip` in CW: cycles from the first streamed sample to the first captured output; sampled when the run starts
- `ld_we` in 1: write enable for the stimulus buffer
- `ld_addr` in AW: stimulus buffer write address
- `ld_re`, `ld_im` in DW each: stimulus sample to write
- `rd_addr` in AW: capture buffer read address
- `rd_re`, `rd_im` out DW each: captured sample, registered
- `fft_valid` out 1: drives `Top_FFT.valid`
- `fft_start` out 1: drives `Top_FFT.start`
- `fft_inReal`, `fft_inImag` out DW each: drive the FFT inputs
- `fft_outReal`, `fft_outImag` in DW each: FFT outputs
- `busy` out 1: high in RUN
- `done` out 1: 1-cycle pulse on the last cycle of each run
- `frame_cnt` out 8: runs completed since reset; wraps at 255→0

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE→RUN and DONE→RUN occur on `run`=1.
- In RUN, cycle counter `c` starts at 0 and increments every cycle.
- The run ends at the cycle where `c == E-1`, with E = max(FRAME_LEN, skip_l + CAP_LEN). `skip_l` is the value of `skip` latched at run start.
- At run end: if `loop`=1 the FSM stays in RUN with `c`=0 and `skip_l` re-latched; otherwise it goes to DONE.
- `done` pulses on the end cycle, and `frame_cnt` increments on that same cycle.
- Streaming: for `c` < FRAME_LEN, `fft_valid`=1 and `fft_inReal`/`fft_inImag` = stimulus[c].
- `fft_start`=1 only on cycles where `c`=0.
- For `c` ≥ FRAME_LEN, `fft_valid`=0 and the data outputs are 0.
- Capture: for skip_l ≤ `c` < skip_l + CAP_LEN, `fft_outReal`/`fft_outImag` are written to capture[c − skip_l] on that same edge. Capture may overlap streaming when skip_l < FRAME_LEN.
- Stimulus writes are accepted only in IDLE or DONE. During RUN, `ld_we` is ignored.
- A stimulus write with `ld_addr` ≥ FRAME_LEN is ignored.
- The capture buffer can be read in any state.
- `rd_addr` ≥ CAP_LEN returns 0.
- Reading an address in the same cycle it is written returns the old data.
- A `run` pulse during RUN is ignored.
- `skip` changes take effect at the next run start.
- Reset mid-run: all state is cleared immediately and the FSM returns to IDLE.
- Buffer contents are not reset. The bench must load the stimulus before the first run.

## Timing
- Reset values: state=IDLE, `c`=0, `fft_valid`=0, `fft_start`=0, `fft_inReal`=`fft_inImag`=0, `busy`=0, `done`=0, `frame_cnt`=0, `rd_re`=`rd_im`=0.
- The FFT-facing outputs are registered. `run` sampled at edge T gives `c`=0, `fft_start`=1, `fft_valid`=1 and stimulus[0] valid after edge T+1.
- Sample k is on the FFT inputs during cycle T+1+k.
- The FFT output present during cycle T+1+skip_l+j is stored to capture[j].
- Stimulus reads are internal with zero visible latency. Prefetch is done during the IDLE/DONE→RUN transition.
- Capture read latency is 1 cycle: `rd_addr` at edge N appears on `rd_re`/`rd_im` after edge N.
- In loop mode the runs are back-to-back: `fft_start` is high again on the cycle immediately after `done`, with no gap cycle.

## Test plan
- Load stimulus[i] = i (re) and −i (im), `skip`=0, run → `fft_in` carries 0..383 on consecutive cycles and `fft_start` is high only with sample 0. The `fft_out` port is tied to `fft_in`, so capture[j] = j; read back with 1-cycle latency.
- `skip`=140, `fft_out` driven as a cycle counter → capture[0] holds the value seen 140 cycles after sample 0. `done` fires at `c`=523 (E=524). `busy` is high for exactly 524 cycles.
- `loop`=1 for 3 runs → 3 `done` pulses, 524 cycles apart, with no gap cycle. `frame_cnt`=3 and `fft_start` pulses 3 times.
- `ld_we` during RUN, plus a write at address 400 in IDLE → stimulus unchanged. Subsequent stream identical to the previous one.
- `reset_n` low at `c`=200 → all outputs at reset values asynchronously, state IDLE. A new `run` restarts from sample 0.
- `run` pulse during RUN, plus `rd_addr`=500 → no restart or timing change, and `rd_re`=`rd_im`=0.
